nic_fifo_param: RTL and testbench

- Parametrised successor to the single-entry per-node NIC in the 4-node CMP.
- Sits between a node processor's NIC port (addr_nic/nicEn/nicWrEn/din/dout) and its router port.
- Replaces the one-packet input and output buffers with configurable-depth FIFOs and adds occupancy/overflow status.
- Outgoing data uses a ready/send handshake; incoming data uses a send/ready handshake.

---
 rtl/nic_fifo_param.sv | 157 +++++++++++++++
 tb/tb_nic_fifo_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nic_fifo_param.sv
// Processor/router NIC with configurable-depth ingress and egress FIFOs plus status words.
// Optional NIC_POLARITY_EN: adds a polarity input that gates egress and shows in output status bit 2.
module nic_fifo_param #(
  parameter int DATA_W    = 64,
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:1]        addr_nic,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic [0:DATA_W-1] din_nic,
  output logic [0:DATA_W-1] dout_nic,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di
`ifdef NIC_POLARITY_EN
  ,
  input  logic              polarity
`endif
);

  localparam int IPW = $clog2(IN_DEPTH);
  localparam int ICW = IPW + 1;
  localparam int OPW = $clog2(OUT_DEPTH);
  localparam int OCW = OPW + 1;

  logic [0:DATA_W-1] in_mem  [IN_DEPTH];
  logic [0:DATA_W-1] out_mem [OUT_DEPTH];

  logic [IPW-1:0] in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
  logic [ICW-1:0] in_count_q, in_count_d;
  logic           in_ovf_q, in_ovf_d;
  logic [OPW-1:0] out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
  logic [OCW-1:0] out_count_q, out_count_d;
  logic           out_ovf_q, out_ovf_d;
  logic [0:DATA_W-1] dout_q, dout_d, net_do_q, net_do_d;
  logic           net_so_q, net_so_d;

  logic rd_en, wr_en, pol_bit, pol_ok;
  logic in_full, in_empty, in_push, in_pop, in_ovf_set, in_ovf_clr;
  logic out_full, out_empty, out_push, out_pop, out_ovf_set, out_ovf_clr;
  logic [0:DATA_W-1] in_status, out_status;

`ifdef NIC_POLARITY_EN
  assign pol_bit = polarity;
`else
  assign pol_bit = 1'b0;
`endif
  assign pol_ok = ~pol_bit;

  assign rd_en     = nicEn & ~nicWrEn;
  assign wr_en     = nicEn & nicWrEn;
  assign in_full   = (in_count_q == ICW'(IN_DEPTH));
  assign in_empty  = (in_count_q == '0);
  assign out_full  = (out_count_q == OCW'(OUT_DEPTH));
  assign out_empty = (out_count_q == '0);

  // A push into a full FIFO is taken when the same cycle frees a slot.
  always_comb begin
    in_pop      = rd_en && (addr_nic == 2'b00) && !in_empty;
    in_push     = net_si && (!in_full || in_pop);
    in_ovf_set  = net_si && in_full && !in_pop;
    in_ovf_clr  = rd_en && (addr_nic == 2'b01);
    out_pop     = !out_empty && net_ro && pol_ok;
    out_push    = wr_en && (addr_nic == 2'b10) && (!out_full || out_pop);
    out_ovf_set = wr_en && (addr_nic == 2'b10) && out_full && !out_pop;
    out_ovf_clr = rd_en && (addr_nic == 2'b11);
  end

  always_comb begin
    in_status                    = '0;
    in_status[0]                 = in_full;
    in_status[1]                 = in_ovf_q;
    in_status[DATA_W-ICW +: ICW] = in_count_q;
    out_status                    = '0;
    out_status[0]                 = out_full;
    out_status[1]                 = out_ovf_q;
    out_status[2]                 = pol_bit;
    out_status[DATA_W-OCW +: OCW] = out_count_q;
  end

  always_comb begin
    in_wr_ptr_d = in_push ? in_wr_ptr_q + 1'b1 : in_wr_ptr_q;
    in_rd_ptr_d = in_pop  ? in_rd_ptr_q + 1'b1 : in_rd_ptr_q;
    in_count_d  = in_count_q;
    if (in_push && !in_pop)      in_count_d = in_count_q + 1'b1;
    else if (in_pop && !in_push) in_count_d = in_count_q - 1'b1;
    // Set beats clear when both land in one cycle.
    in_ovf_d = in_ovf_set ? 1'b1 : (in_ovf_clr ? 1'b0 : in_ovf_q);

    out_wr_ptr_d = out_push ? out_wr_ptr_q + 1'b1 : out_wr_ptr_q;
    out_rd_ptr_d = out_pop  ? out_rd_ptr_q + 1'b1 : out_rd_ptr_q;
    out_count_d  = out_count_q;
    if (out_push && !out_pop)      out_count_d = out_count_q + 1'b1;
    else if (out_pop && !out_push) out_count_d = out_count_q - 1'b1;
    out_ovf_d = out_ovf_set ? 1'b1 : (out_ovf_clr ? 1'b0 : out_ovf_q);
  end

  always_comb begin
    dout_d = dout_q;
    if (rd_en) begin
      case (addr_nic)
        2'b00:   dout_d = in_pop ? in_mem[in_rd_ptr_q] : '0;
        2'b01:   dout_d = in_status;
        2'b10:   dout_d = '0;
        default: dout_d = out_status;
      endcase
    end
    net_so_d = out_pop;
    net_do_d = out_pop ? out_mem[out_rd_ptr_q] : net_do_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr_ptr_q  <= '0;
      in_rd_ptr_q  <= '0;
      in_count_q   <= '0;
      in_ovf_q     <= 1'b0;
      out_wr_ptr_q <= '0;
      out_rd_ptr_q <= '0;
      out_count_q  <= '0;
      out_ovf_q    <= 1'b0;
      dout_q       <= '0;
      net_so_q     <= 1'b0;
      net_do_q     <= '0;
    end else begin
      in_wr_ptr_q  <= in_wr_ptr_d;
      in_rd_ptr_q  <= in_rd_ptr_d;
      in_count_q   <= in_count_d;
      in_ovf_q     <= in_ovf_d;
      out_wr_ptr_q <= out_wr_ptr_d;
      out_rd_ptr_q <= out_rd_ptr_d;
      out_count_q  <= out_count_d;
      out_ovf_q    <= out_ovf_d;
      dout_q       <= dout_d;
      net_so_q     <= net_so_d;
      net_do_q     <= net_do_d;
    end
  end

  // Storage needs no reset: cleared pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr_ptr_q]   <= net_di;
    if (out_push) out_mem[out_wr_ptr_q] <= din_nic;
  end

  assign dout_nic = dout_q;
  assign net_so   = net_so_q;
  assign net_do   = net_do_q;
  assign net_ri   = reset & ~in_full;

endmodule

// File: tb/tb_nic_fifo_param.sv
// Directed bench for nic_fifo_param: a table of per-cycle vectors plus reset and polarity sequences.
module tb_nic_fifo_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [0:1]  addr_nic = 2'b00;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic [0:63] din_nic = '0;
  logic [0:63] dout_nic;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [0:63] net_do;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [0:63] net_di = '0;
`ifdef NIC_POLARITY_EN
  logic        polarity = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [0:63] ST_FULL     = 64'h8000_0000_0000_0004;
  localparam logic [0:63] ST_FULL_OVF = 64'hC000_0000_0000_0004;

  typedef struct {
    logic        en, wr;
    logic [1:0]  addr;
    logic [63:0] din;
    logic        ro, si;
    logic [63:0] di;
    logic        eso;
    logic [63:0] edo;
    logic        eri;
    logic [63:0] edout;
  } vec_t;

  vec_t vecs[$];

  nic_fifo_param dut (
    .clk(clk), .reset(reset), .addr_nic(addr_nic), .nicEn(nicEn), .nicWrEn(nicWrEn),
    .din_nic(din_nic), .dout_nic(dout_nic), .net_so(net_so), .net_ro(net_ro),
    .net_do(net_do), .net_si(net_si), .net_ri(net_ri), .net_di(net_di)
`ifdef NIC_POLARITY_EN
    , .polarity(polarity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic wr, input logic [1:0] addr, input logic [63:0] din,
                     input logic ro, input logic si, input logic [63:0] di,
                     input logic eso, input logic [63:0] edo, input logic eri, input logic [63:0] edout);
    vec_t v;
    v.en = en; v.wr = wr; v.addr = addr; v.din = din; v.ro = ro; v.si = si; v.di = di;
    v.eso = eso; v.edo = edo; v.eri = eri; v.edout = edout;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic en, input logic wr, input logic [1:0] addr, input logic [63:0] din,
                       input logic ro, input logic si, input logic [63:0] di);
    @(negedge clk);
    nicEn = en; nicWrEn = wr; addr_nic = addr; din_nic = din;
    net_ro = ro; net_si = si; net_di = di;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // en wr addr din ro si di | so do ri dout
    add(1,0,2'b01,0,    0,0,0,    0,0,1,0);
    add(1,1,2'b10,'h11, 0,0,0,    0,0,1,0);
    add(1,1,2'b10,'h22, 0,0,0,    0,0,1,0);
    add(1,1,2'b10,'h33, 0,0,0,    0,0,1,0);
    add(1,1,2'b10,'h44, 0,0,0,    0,0,1,0);
    add(1,1,2'b10,'h55, 0,0,0,    0,0,1,0);
    add(1,0,2'b11,0,    0,0,0,    0,0,1,ST_FULL_OVF);
    add(1,0,2'b11,0,    0,0,0,    0,0,1,ST_FULL);
    add(1,1,2'b00,'hFF, 0,0,0,    0,0,1,ST_FULL);
    add(0,0,2'b00,0,    1,0,0,    1,'h11,1,ST_FULL);
    add(0,0,2'b00,0,    1,0,0,    1,'h22,1,ST_FULL);
    add(0,0,2'b00,0,    1,0,0,    1,'h33,1,ST_FULL);
    add(0,0,2'b00,0,    1,0,0,    1,'h44,1,ST_FULL);
    add(0,0,2'b00,0,    1,0,0,    0,'h44,1,ST_FULL);
    add(1,0,2'b10,0,    0,0,0,    0,'h44,1,0);
    add(0,0,2'b00,0,    0,1,'hA0, 0,'h44,1,0);
    add(0,0,2'b00,0,    0,1,'hA1, 0,'h44,1,0);
    add(0,0,2'b00,0,    0,1,'hA2, 0,'h44,1,0);
    add(0,0,2'b00,0,    0,1,'hA3, 0,'h44,0,0);
    add(0,0,2'b00,0,    0,1,'hA4, 0,'h44,0,0);
    add(1,0,2'b01,0,    0,0,0,    0,'h44,0,ST_FULL_OVF);
    add(1,0,2'b01,0,    0,0,0,    0,'h44,0,ST_FULL);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,'hA0);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,'hA1);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,'hA2);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,'hA3);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,0);
    add(1,0,2'b01,0,    0,0,0,    0,'h44,1,0);
    // full input FIFO: simultaneous pop and push
    add(0,0,2'b00,0,    0,1,'hC0, 0,'h44,1,0);
    add(0,0,2'b00,0,    0,1,'hC1, 0,'h44,1,0);
    add(0,0,2'b00,0,    0,1,'hC2, 0,'h44,1,0);
    add(0,0,2'b00,0,    0,1,'hC3, 0,'h44,0,0);
    add(1,0,2'b00,0,    0,1,'hB0, 0,'h44,0,'hC0);
    add(1,0,2'b01,0,    0,0,0,    0,'h44,0,ST_FULL);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,'hC1);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,'hC2);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,'hC3);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,'hB0);
    // empty pop with push: no bypass
    add(1,0,2'b00,0,    0,1,'hD0, 0,'h44,1,0);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,'hD0);
    // overflow set and status clear in the same cycle
    add(0,0,2'b00,0,    0,1,'hF0, 0,'h44,1,'hD0);
    add(0,0,2'b00,0,    0,1,'hF1, 0,'h44,1,'hD0);
    add(0,0,2'b00,0,    0,1,'hF2, 0,'h44,1,'hD0);
    add(0,0,2'b00,0,    0,1,'hF3, 0,'h44,0,'hD0);
    add(1,0,2'b01,0,    0,1,'hF4, 0,'h44,0,ST_FULL);
    add(1,0,2'b01,0,    0,0,0,    0,'h44,0,ST_FULL_OVF);
    add(1,0,2'b01,0,    0,0,0,    0,'h44,0,ST_FULL);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,'hF0);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,'hF1);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,'hF2);
    add(1,0,2'b00,0,    0,0,0,    0,'h44,1,'hF3);
    // full output FIFO: push accepted alongside egress pop
    add(1,1,2'b10,'hE0, 0,0,0,    0,'h44,1,'hF3);
    add(1,1,2'b10,'hE1, 0,0,0,    0,'h44,1,'hF3);
    add(1,1,2'b10,'hE2, 0,0,0,    0,'h44,1,'hF3);
    add(1,1,2'b10,'hE3, 0,0,0,    0,'h44,1,'hF3);
    add(1,1,2'b10,'hE4, 1,0,0,    1,'hE0,1,'hF3);
    add(1,0,2'b11,0,    1,0,0,    1,'hE1,1,ST_FULL);
    add(0,0,2'b00,0,    1,0,0,    1,'hE2,1,ST_FULL);
    add(0,0,2'b00,0,    1,0,0,    1,'hE3,1,ST_FULL);
    add(0,0,2'b00,0,    1,0,0,    1,'hE4,1,ST_FULL);
    add(0,0,2'b00,0,    1,0,0,    0,'hE4,1,ST_FULL);
    add(1,0,2'b11,0,    0,0,0,    0,'hE4,1,0);

    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("rst_so", 64'(net_so), 0);
      check("rst_do", net_do, 0);
      check("rst_dout", dout_nic, 0);
      check("rst_ri", 64'(net_ri), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_ri", 64'(net_ri), 1);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].ro, vecs[i].si, vecs[i].di);
      check($sformatf("v%0d_so", i), 64'(net_so), 64'(vecs[i].eso));
      check($sformatf("v%0d_do", i), net_do, vecs[i].edo);
      check($sformatf("v%0d_ri", i), 64'(net_ri), 64'(vecs[i].eri));
      check($sformatf("v%0d_dout", i), dout_nic, vecs[i].edout);
    end

    // Asynchronous reset in the middle of traffic discards everything.
    drive(1,1,2'b10,'h77, 0,1,'h99);
    drive(1,0,2'b11,0,    0,0,0);
    check("pre_rst_dout", dout_nic, 64'h1);
    @(negedge clk);
    nicEn = 1'b0; net_si = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_do", net_do, 0);
    check("mid_rst_dout", dout_nic, 0);
    check("mid_rst_ri", 64'(net_ri), 0);
    @(negedge clk);
    reset = 1'b1;
    drive(1,0,2'b01,0, 1,0,0);
    check("post_rst_in_st", dout_nic, 0);
    check("post_rst_so", 64'(net_so), 0);
    drive(1,0,2'b11,0, 1,0,0);
    check("post_rst_out_st", dout_nic, 0);

`ifdef NIC_POLARITY_EN
    begin
      int sends = 0;
      drive(1,1,2'b10,'h61, 0,0,0);
      drive(1,1,2'b10,'h62, 0,0,0);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        nicEn = 1'b0; net_ro = 1'b1; polarity = 1'(i % 2);
        @(posedge clk);
        #1;
        check($sformatf("pol%0d_so", i), 64'(net_so), 64'(i % 2 == 0));
        if (net_so) sends++;
      end
      check("pol_do", net_do, 'h62);
      check("pol_sends", 64'(sends), 2);
      @(negedge clk);
      polarity = 1'b1;
      drive(1,0,2'b11,0, 0,0,0);
      check("pol_status", dout_nic, 64'h2000_0000_0000_0000);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
